// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (req0) and load (req1) writeback.
// One grant per cycle, registered write outputs, writes to register 0 are accepted but dropped.
module regfile_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic          we3,
  output logic [AW-1:0] a3,
  output logic [DW-1:0] wd3,
  output logic [CW-1:0] wr_count,
  output logic [CW-1:0] conflict_count,
  output logic [CW-1:0] drop_count
);

  logic          last_grant;
  logic          grant0;
  logic          grant1;
  logic          xfer;
  logic          issue;
  logic          drop;
  logic          both;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // Ready depends only on the valids and last_grant; both are held low during reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n) begin
      if (req0_valid && (!req1_valid || last_grant))
        grant0 = 1'b1;
      else if (req1_valid)
        grant1 = 1'b1;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign xfer       = grant0 | grant1;
  assign sel_addr   = grant1 ? req1_addr : req0_addr;
  assign sel_data   = grant1 ? req1_data : req0_data;
  assign issue      = xfer && (sel_addr != '0);
  assign drop       = xfer && (sel_addr == '0);
  assign both       = req0_valid && req1_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant     <= 1'b1;
      we3            <= 1'b0;
      a3             <= '0;
      wd3            <= '0;
      wr_count       <= '0;
      conflict_count <= '0;
      drop_count     <= '0;
    end else begin
      we3 <= issue;
      if (issue) begin
        a3       <= sel_addr;
        wd3      <= sel_data;
        wr_count <= sat_inc(wr_count);
      end
      if (xfer)
        last_grant <= grant1;
      if (drop)
        drop_count <= sat_inc(drop_count);
      if (both)
        conflict_count <= sat_inc(conflict_count);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a randomized run against a behavioural model.
module tb_regfile_wb_arbiter;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          we3;
  logic [AW-1:0] a3;
  logic [DW-1:0] wd3;
  logic [CW-1:0] wr_count;
  logic [CW-1:0] conflict_count;
  logic [CW-1:0] drop_count;

  int vectors;
  int errors;

  // Behavioural model state
  int          m_last;
  logic        m_we;
  logic [4:0]  m_a;
  logic [31:0] m_wd;
  int          m_wr;
  int          m_cf;
  int          m_dr;
  logic [31:0] exp_rf [32];
  logic [31:0] dut_rf [32];

  regfile_wb_arbiter #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .we3(we3), .a3(a3), .wd3(wd3),
    .wr_count(wr_count), .conflict_count(conflict_count), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (we3) dut_rf[a3] <= wd3;

  function automatic int sat(input int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  // Who should be granted right now: -1 none, 0 or 1.
  function automatic int exp_grant();
    if (!rst_n) return -1;
    if (req0_valid && req1_valid) return 1 - m_last;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  // Advance model and DUT by one clock; inputs must already be stable.
  task automatic step();
    int g;
    logic [4:0]  ad;
    logic [31:0] dt;
    g = exp_grant();
    if (m_we) exp_rf[m_a] = m_wd;
    if (!rst_n) begin
      m_we = 1'b0; m_a = '0; m_wd = '0; m_wr = 0; m_cf = 0; m_dr = 0; m_last = 1;
    end else begin
      if (req0_valid && req1_valid) m_cf = sat(m_cf);
      if (g >= 0) begin
        m_last = g;
        ad = (g == 1) ? req1_addr : req0_addr;
        dt = (g == 1) ? req1_data : req0_data;
        if (ad != 0) begin
          m_we = 1'b1; m_a = ad; m_wd = dt; m_wr = sat(m_wr);
        end else begin
          m_we = 1'b0; m_dr = sat(m_dr);
        end
      end else begin
        m_we = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    vectors++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL rst_ready0 got %b want 0", req0_ready); end
    vectors++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL rst_ready1 got %b want 0", req1_ready); end
    step(); step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    vectors++; if (we3 !== 1'b0) begin errors++; $display("FAIL rst_we3 got %b want 0", we3); end
    vectors++; if (a3 !== '0) begin errors++; $display("FAIL rst_a3 got %h want 0", a3); end
    vectors++; if (wd3 !== '0) begin errors++; $display("FAIL rst_wd3 got %h want 0", wd3); end
    vectors++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %b%b want 00", req0_ready, req1_ready); end
    vectors++; if (wr_count !== '0 || conflict_count !== '0 || drop_count !== '0) begin
      errors++; $display("FAIL rst_counts got %0d/%0d/%0d want 0/0/0", wr_count, conflict_count, drop_count); end
  endtask

  task automatic test_single_write();
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hDEADBEEF;
    #1;
    vectors++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready got %b%b want 10", req0_ready, req1_ready); end
    step();
    req0_valid = 1'b0;
    vectors++; if (we3 !== 1'b1) begin errors++; $display("FAIL single_we3 got %b want 1", we3); end
    vectors++; if (a3 !== 5'd3) begin errors++; $display("FAIL single_a3 got %0d want 3", a3); end
    vectors++; if (wd3 !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wd3 got %h want deadbeef", wd3); end
    step();
    vectors++; if (we3 !== 1'b0) begin errors++; $display("FAIL single_we3_off got %b want 0", we3); end
    vectors++; if (int'(wr_count) !== 1) begin errors++; $display("FAIL single_wr_count got %0d want 1", wr_count); end
  endtask

  task automatic test_alternate();
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h11;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++; if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
        errors++; $display("FAIL alt_grant[%0d] got %b%b want %b%b", i, req0_ready, req1_ready, i % 2 == 0, i % 2 == 1); end
      step();
      vectors++; if (we3 !== 1'b1 || a3 !== ((i % 2 == 0) ? 5'd1 : 5'd2) || wd3 !== ((i % 2 == 0) ? 32'h11 : 32'h22)) begin
        errors++; $display("FAIL alt_out[%0d] got we=%b a=%0d d=%h", i, we3, a3, wd3); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    vectors++; if (int'(conflict_count) !== 4) begin errors++; $display("FAIL alt_conflicts got %0d want 4", conflict_count); end
    vectors++; if (int'(wr_count) !== 4) begin errors++; $display("FAIL alt_wr_count got %0d want 4", wr_count); end
  endtask

  task automatic test_same_addr();
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'hA;
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'hB;
    #1;
    vectors++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL same_first_ready0 got %b want 1", req0_ready); end
    step();
    req0_valid = 1'b0;
    #1;
    vectors++; if (a3 !== 5'd7 || wd3 !== 32'hA) begin errors++; $display("FAIL same_n1 got a=%0d d=%h want 7/a", a3, wd3); end
    vectors++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL same_ready1 got %b want 1", req1_ready); end
    step();
    req1_valid = 1'b0;
    vectors++; if (we3 !== 1'b1 || a3 !== 5'd7 || wd3 !== 32'hB) begin errors++; $display("FAIL same_n2 got we=%b a=%0d d=%h want 1/7/b", we3, a3, wd3); end
    step();
    vectors++; if (dut_rf[7] !== 32'hB || exp_rf[7] !== 32'hB) begin errors++; $display("FAIL same_rf7 got %h want b", dut_rf[7]); end
  endtask

  task automatic test_drop_r0();
    do_reset();
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h55;
    #1;
    vectors++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL drop_ready1 got %b want 1", req1_ready); end
    step();
    req1_valid = 1'b0;
    vectors++; if (we3 !== 1'b0) begin errors++; $display("FAIL drop_we3 got %b want 0", we3); end
    step();
    vectors++; if (int'(drop_count) !== 1) begin errors++; $display("FAIL drop_count got %0d want 1", drop_count); end
    vectors++; if (int'(wr_count) !== 0) begin errors++; $display("FAIL drop_wr_count got %0d want 0", wr_count); end
  endtask

  task automatic test_reset_mid();
    req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h1234;
    #1;
    step();
    rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; req1_addr = 5'd5; req1_data = 32'h5678;
    #1;
    vectors++; if (we3 !== 1'b1) begin errors++; $display("FAIL mid_we3_before got %b want 1", we3); end
    vectors++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL mid_ready got %b%b want 00", req0_ready, req1_ready); end
    step();
    vectors++; if (we3 !== 1'b0) begin errors++; $display("FAIL mid_we3_after got %b want 0", we3); end
    vectors++; if (wr_count !== '0 || conflict_count !== '0 || drop_count !== '0) begin
      errors++; $display("FAIL mid_counts got %0d/%0d/%0d want 0/0/0", wr_count, conflict_count, drop_count); end
    rst_n = 1'b1;
    #1;
    vectors++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL mid_regrant got %b%b want 10", req0_ready, req1_ready); end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
  endtask

  task automatic test_saturate();
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < MAXC + 6; i++) begin
      req0_addr = 5'($urandom_range(1, 31)); req0_data = $urandom;
      req1_addr = 5'($urandom_range(1, 31)); req1_data = $urandom;
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    vectors++; if (int'(wr_count) !== MAXC) begin errors++; $display("FAIL sat_wr got %0d want %0d", wr_count, MAXC); end
    vectors++; if (int'(conflict_count) !== MAXC) begin errors++; $display("FAIL sat_conflict got %0d want %0d", conflict_count, MAXC); end
  endtask

  task automatic test_random();
    int g;
    do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 50) == 0) ? 1'b0 : 1'b1;
      #1;
      g = exp_grant();
      vectors++; if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
        errors++; $display("FAIL rnd_grant[%0d] got %b%b want grant %0d", c, req0_ready, req1_ready, g); end
      step();
      vectors++; if (we3 !== m_we || (m_we && (a3 !== m_a || wd3 !== m_wd))) begin
        errors++; $display("FAIL rnd_out[%0d] got %b/%0d/%h want %b/%0d/%h", c, we3, a3, wd3, m_we, m_a, m_wd); end
      vectors++; if (int'(wr_count) !== m_wr || int'(conflict_count) !== m_cf || int'(drop_count) !== m_dr) begin
        errors++; $display("FAIL rnd_counts[%0d] got %0d/%0d/%0d want %0d/%0d/%0d", c, wr_count, conflict_count, drop_count, m_wr, m_cf, m_dr); end
      // Requesters hold until accepted, then maybe present a new write.
      if (!req0_valid || g == 0) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        req0_data = $urandom;
      end
      if (!req1_valid || g == 1) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        req1_data = $urandom;
      end
    end
    rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    step(); step();
    for (int r = 1; r < 32; r++) begin
      vectors++; if (exp_rf[r] !== 32'h0 && dut_rf[r] !== exp_rf[r]) begin
        errors++; $display("FAIL rnd_rf[%0d] got %h want %h", r, dut_rf[r], exp_rf[r]); end
    end
  endtask

  initial begin
    vectors = 0; errors = 0;
    m_last = 1; m_we = 1'b0; m_a = '0; m_wd = '0; m_wr = 0; m_cf = 0; m_dr = 0;
    for (int r = 0; r < 32; r++) exp_rf[r] = 32'h0;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_write();
    test_alternate();
    test_same_addr();
    test_drop_r0();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (a3/we3/wd3) between two writeback requesters: req0 (ALU result) and req1 (load data from memory).
- Each requester uses a valid/ready handshake. Arbitration is round-robin with one grant per cycle.
- Write outputs are registered and drive the register file write port directly.
- Keeps saturating statistics counters for debug.

Parameters:
- DW, 32, data width of a write.
- AW, 5, register address width.
- CW, 16, width of the statistics counters.

Ports:
- clk  input  1  clock; all state updates on its rising edge
- rst_n  input  1  synchronous, active-low reset
- req0_valid  input  1  requester 0 has a write pending
- req0_addr  input  AW  requester 0 destination register
- req0_data  input  DW  requester 0 write data
- req0_ready  output  1  requester 0 write accepted this cycle
- req1_valid  input  1  requester 1 has a write pending
- req1_addr  input  AW  requester 1 destination register
- req1_data  input  DW  requester 1 write data
- req1_ready  output  1  requester 1 write accepted this cycle
- we3  output  1  register-file write enable (registered)
- a3  output  AW  register-file write address (registered)
- wd3  output  DW  register-file write data (registered)
- wr_count  output  CW  number of writes issued with we3=1, saturating
- conflict_count  output  CW  number of cycles with both valids high, saturating
- drop_count  output  CW  number of accepted writes to register 0, saturating

Behaviour:
- Reset (rst_n=0 at a rising edge): we3=0, a3=0, wd3=0, all counters=0, last_grant=1 (so req0 wins first). Ready outputs are combinational and are 0 while rst_n=0.
- Handshake: a transfer happens when reqN_valid=1 and reqN_ready=1 in the same cycle.
  - Requester must hold valid, addr and data stable until accepted.
  - Ready is combinational from the valids and last_grant, with no dependence on ready.
- Grant rules (combinational, at most one per cycle):
  - Only req0_valid high: req0_ready=1.
  - Only req1_valid high: req1_ready=1.
  - Both high: grant the requester not equal to last_grant.
  - Neither high: no grant.
- last_grant updates to the granted index on every transfer; unchanged otherwise.
- Output register, every cycle:
  - If a transfer occurred with addr!=0: we3<=1, a3<=addr, wd3<=data.
  - Otherwise: we3<=0, a3 and wd3 hold their previous values.
- Latency: a write accepted in cycle N gives we3=1 in cycle N+1. The register file captures it at the end of N+1, so it is readable in N+2.
- Register 0:
  - A write to addr 0 is accepted (ready=1) but never issued; we3 stays 0 for that slot and drop_count increments.
  - Register 0 reads as zero, so the write is architecturally a no-op.
- Throughput: one write per cycle. The register file never stalls, so there is no backpressure from the output side.
- Same-address conflict: both valid with equal addr gives the round-robin winner in cycle N+1 and the loser in cycle N+2. The loser's data is final in the register file; this ordering is the defined outcome.
- conflict_count increments in every cycle where both valids are high.
- Counters: increment by 1 and saturate at 2^CW-1, with no wrap.
- Reset mid-operation: any write held in the output register is discarded (we3=0 the next cycle). Pending requests are not accepted during reset and are re-arbitrated after reset with req0 first.

Test Plan:
- Reset then idle 5 cycles -> we3=0, a3=0, wd3=0, both readys 0, all counters 0.
- req0 only, addr=3, data=0xDEADBEEF, held 1 cycle -> req0_ready=1 in cycle N; in N+1 we3=1, a3=3, wd3=0xDEADBEEF; wr_count=1.
- Both valid for 4 consecutive transfers, req0 addr=1/data=0x11, req1 addr=2/data=0x22 -> grants alternate 0,1,0,1; we3 stays high 4 cycles with a3 sequence 1,2,1,2; conflict_count counts every both-valid cycle.
- Both valid, same addr=7, req0 data=0xA, req1 data=0xB, fresh after reset -> a3=7/wd3=0xA in N+1, a3=7/wd3=0xB in N+2; register 7 ends at 0xB.
- req1 addr=0, data=0x55 -> req1_ready=1, we3 stays 0, drop_count=1, wr_count unchanged.
- Transfer in cycle N with rst_n=0 in cycle N+1 -> we3=0 in N+2, counters 0, next simultaneous request granted to req0.
